// File: rtl/neo_capture_buffer.sv
// Trigger-gated trace capture FIFO: arms, waits for a qualified trigger word, stores up to
// capture_len words and presents them on a first-word-fall-through pop port.
//
// state   | meaning
// IDLE    | no session; trace words ignored
// ARMED   | waiting for trig & cap_valid; that word starts the capture
// CAPTURE | storing valid words until the session length is reached
// DONE    | session complete; FIFO holds the captured words

module neo_capture_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  flush,
    input  logic [CNT_WIDTH-1:0]  capture_len,
    input  logic                  trig,
    input  logic                  cap_valid,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  rd_pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]  level,
    output logic [1:0]            state,
    output logic                  overflow,
    output logic                  done_irq
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, rd_cnt_q;
    logic [CNT_WIDTH-1:0]  stored_q, len_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  overflow_q, done_irq_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  full, cap_win, pop_ok, push_ok, drop;
    logic                  session_start, done_hit;
    logic [CNT_WIDTH-1:0]  stored_inc, level_next;
    logic [ADDR-1:0]       wr_ptr, rd_ptr, rd_ptr_next;

    assign level    = wr_cnt_q - rd_cnt_q;
    assign rd_valid = (level != '0);
    assign full     = (level == DEPTH_CNT);
    assign wr_ptr   = wr_cnt_q[ADDR-1:0];
    assign rd_ptr   = rd_cnt_q[ADDR-1:0];

    // The triggering word in ARMED is part of the session, so it shares the capture window.
    assign cap_win    = !abort && ((state_q == CAPTURE) || (state_q == ARMED && trig));
    assign pop_ok     = rd_pop && rd_valid && !flush;
    assign push_ok    = cap_win && cap_valid && !flush && (!full || pop_ok);
    assign drop       = cap_win && cap_valid && !flush && full && !pop_ok;
    assign stored_inc = stored_q + CNT_WIDTH'(1);
    assign done_hit   = push_ok && (stored_inc == len_q);

    always_comb begin
        state_d       = state_q;
        session_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm && !abort) begin
                    state_d       = ARMED;
                    session_start = 1'b1;
                end
            end
            ARMED: begin
                if (abort)                  state_d = IDLE;
                else if (trig && cap_valid) state_d = done_hit ? DONE : CAPTURE;
            end
            CAPTURE: begin
                if (abort)         state_d = IDLE;
                else if (done_hit) state_d = DONE;
            end
            DONE: begin
                if (abort) state_d = IDLE;
                else if (arm) begin
                    state_d       = ARMED;
                    session_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            stored_q   <= '0;
            len_q      <= DEPTH_CNT;
            done_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_irq_q <= (state_q != DONE) && (state_d == DONE);
            if (session_start) begin
                stored_q <= '0;
                len_q    <= (capture_len == '0) ? DEPTH_CNT : capture_len;
            end else if (push_ok) begin
                stored_q <= stored_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= cap_data;
    end

    // Registered FWFT head: the word that will be at the head after this edge, bypassing
    // the array when that word is the one being written now.
    assign rd_ptr_next = rd_ptr + ADDR'(pop_ok);
    assign level_next  = level + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
            if (pop_ok)  rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
            if (drop)    overflow_q <= 1'b1;
            if (level_next != '0) begin
                if (push_ok && rd_ptr_next == wr_ptr) rd_data_q <= cap_data;
                else                                  rd_data_q <= mem[rd_ptr_next];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign state    = state_q;
    assign overflow = overflow_q;
    assign done_irq = done_irq_q;

endmodule

// File: tb/tb_neo_capture_buffer.sv
// Directed bench for neo_capture_buffer: capture sessions, trigger gating, overflow,
// full push+pop, abort/re-arm and asynchronous reset.

module tb_neo_capture_buffer;

    localparam int DW = 32;
    localparam int DEPTH = 256;
    localparam int CW = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0, abort = 1'b0, flush = 1'b0;
    logic [CW-1:0] capture_len = '0;
    logic          trig = 1'b0, cap_valid = 1'b0, rd_pop = 1'b0;
    logic [DW-1:0] cap_data = '0;
    logic          rd_valid, overflow, done_irq;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] level;
    logic [1:0]    state;

    int n_chk = 0;
    int n_pass = 0;

    neo_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort), .flush(flush),
        .capture_len(capture_len), .trig(trig), .cap_valid(cap_valid), .cap_data(cap_data),
        .rd_pop(rd_pop), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .state(state), .overflow(overflow), .done_irq(done_irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        // reset values
        tick(); tick();
        chk("rst_state", state, 2'd0);
        chk("rst_level", level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done_irq", done_irq, 0);
        reset = 1'b0;
        tick();

        // 1: capture_len=4, words 1..6 -> 1..4 stored
        capture_len = 9'd4; arm = 1'b1; tick(); arm = 1'b0;
        chk("t1_armed", state, 2'd1);
        trig = 1'b1; cap_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cap_data = DW'(i);
            tick();
            if (i == 1) chk("t1_first_head", rd_data, 32'h1);
            if (i == 3) chk("t1_state_cap", state, 2'd2);
            if (i == 4) chk("t1_done_irq", done_irq, 1);
            if (i == 5) chk("t1_irq_pulse", done_irq, 0);
        end
        cap_valid = 1'b0; trig = 1'b0;
        chk("t1_level", level, 4);
        chk("t1_state_done", state, 2'd3);
        rd_pop = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t1_pop%0d", i), rd_data, 64'(i));
            tick();
        end
        rd_pop = 1'b0;
        chk("t1_empty", rd_valid, 0);
        chk("t1_hold", rd_data, 32'h4);

        // 2: trigger gating
        arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cap_data = 32'h10 + DW'(i);
            tick();
        end
        chk("t2_no_store", level, 0);
        chk("t2_still_armed", state, 2'd1);
        trig = 1'b1; cap_data = 32'hA5; tick();
        chk("t2_first_word", rd_data, 32'hA5);
        chk("t2_state_cap", state, 2'd2);
        cap_data = 32'hB0; tick();
        cap_valid = 1'b0;
        chk("t2_level", level, 2);

        // 3: length 0 means DEPTH; preloaded FIFO fills before the session ends
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3_abort_idle", state, 2'd0);
        capture_len = '0; arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cap_data = DW'(i);
            tick();
        end
        cap_valid = 1'b0;
        chk("t3_level_full", level, 256);
        chk("t3_overflow", overflow, 1);
        chk("t3_state_cap", state, 2'd2);
        chk("t3_head", rd_data, 32'hA5);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t3_flush_level", level, 0);
        chk("t3_flush_ovf", overflow, 0);
        chk("t3_flush_state", state, 2'd2);

        // 4: full FIFO, push 0x77 with a pop in the same cycle
        cap_valid = 1'b1; cap_data = 32'h55; tick(); cap_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            cap_data = 32'h100 + DW'(i);
            tick();
        end
        chk("t4_full", level, 256);
        chk("t4_head", rd_data, 32'h55);
        chk("t4_no_ovf_pre", overflow, 0);
        cap_data = 32'h77; rd_pop = 1'b1; tick();
        cap_valid = 1'b0;
        chk("t4_level", level, 256);
        chk("t4_no_ovf", overflow, 0);
        chk("t4_done", state, 2'd3);
        chk("t4_done_irq", done_irq, 1);
        for (int i = 0; i < 256; i++) begin
            if (i == 0)   chk("t4_next_head", rd_data, 32'h100);
            if (i == 255) chk("t4_last_word", rd_data, 32'h77);
            tick();
        end
        rd_pop = 1'b0;
        chk("t4_drained", rd_valid, 0);

        // 5: abort mid-session, then re-arm restarts the count
        capture_len = 9'd8; arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1; cap_data = 32'hC1; tick(); cap_data = 32'hC2; tick();
        cap_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_idle", state, 2'd0);
        chk("t5_level", level, 2);
        chk("t5_no_irq", done_irq, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cap_data = 32'hD0 + DW'(i);
            tick();
            if (i == 6) chk("t5_not_done_yet", state, 2'd2);
        end
        cap_valid = 1'b0;
        chk("t5_done", state, 2'd3);
        chk("t5_irq", done_irq, 1);
        chk("t5_level10", level, 10);

        // 6: asynchronous reset mid-capture
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_flush_keeps_state", state, 2'd3);
        arm = 1'b1; tick(); arm = 1'b0;
        cap_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cap_data = 32'hE0 + DW'(i);
            tick();
        end
        cap_valid = 1'b0; trig = 1'b0;
        chk("t6_level3", level, 3);
        reset = 1'b1;
        #2;
        chk("t6_rst_state", state, 2'd0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_irq", done_irq, 0);
        tick();
        reset = 1'b0;
        rd_pop = 1'b1; tick(); rd_pop = 1'b0;
        chk("t6_pop_empty_level", level, 0);
        chk("t6_pop_empty_valid", rd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
